// File: rtl/bcd_scan_conv.sv
// Binary-to-BCD converter (shift-add-3, N_in+2 cycles per conversion) feeding a
// multiplexed active-low 7-segment scanner; start is ignored while busy.
module bcd_scan_conv #(
  parameter int N_in     = 10,
  parameter int N_DIG    = 4,
  parameter int N_out    = 7,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_in-1:0]      bin_in,
  input  logic                 start,
  input  logic                 blank_lz,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_DIG-1:0]   bcd_out,
  output logic                 overflow,
  output logic [N_out-1:0]     seg,
  output logic [N_DIG-1:0]     an
);

  localparam int BW = 4 * N_DIG;
  localparam int CW = $clog2(N_in + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]       r_state;
  logic [N_in-1:0]  r_bin;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [BW-1:0]    r_bcd_out;
  logic             r_ovf_out;
  logic             r_done;
  logic [SW-1:0]    r_scan;
  logic [IW-1:0]    r_idx;
  logic [N_DIG-1:0] r_an;
  logic [N_out-1:0] r_seg;

  logic [BW-1:0]    w_adj;
  logic [N_DIG-1:0] w_lz;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_seg;

  function automatic logic [6:0] fn_seg(input logic [3:0] d);
    case (d)
      4'd0:    fn_seg = 7'b1000000;
      4'd1:    fn_seg = 7'b1111001;
      4'd2:    fn_seg = 7'b0100100;
      4'd3:    fn_seg = 7'b0110000;
      4'd4:    fn_seg = 7'b0011001;
      4'd5:    fn_seg = 7'b0010010;
      4'd6:    fn_seg = 7'b0000010;
      4'd7:    fn_seg = 7'b1111000;
      4'd8:    fn_seg = 7'b0000000;
      4'd9:    fn_seg = 7'b0010000;
      default: fn_seg = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < N_DIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // The bit leaving the top digit is dropped, so the register holds the value mod 10^N_DIG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_bcd_out <= '0;
      r_ovf_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin   <= bin_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[BW-2:0], r_bin[N_in-1]};
          r_bin <= {r_bin[N_in-2:0], 1'b0};
          r_ovf <= r_ovf | w_adj[BW-1];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N_in - 1)) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_bcd_out <= r_bcd;
          r_ovf_out <= r_ovf;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // w_lz[i]: digits i..N_DIG-1 are all zero.
  always_comb begin
    logic z;
    z    = 1'b1;
    w_lz = '0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      z       = z & (r_bcd_out[4*i +: 4] == 4'd0);
      w_lz[i] = z;
    end
  end

  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit = r_bcd_out[4*i +: 4];
        w_blank = blank_lz && w_lz[i] && (i != 0);
      end
    end
    w_seg = w_blank ? 7'b1111111 : fn_seg(w_digit);
  end

  // an and seg are both registered from the same index so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_an   <= ~N_DIG'(1);
      r_seg  <= 7'b1000000;
    end else begin
      if (r_scan == SW'(SCAN_DIV - 1)) begin
        r_scan <= '0;
        r_idx  <= (r_idx == IW'(N_DIG - 1)) ? '0 : r_idx + IW'(1);
      end else begin
        r_scan <= r_scan + SW'(1);
      end
      r_an  <= ~(N_DIG'(1) << r_idx);
      r_seg <= w_seg;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign bcd_out  = r_bcd_out;
  assign overflow = r_ovf_out;
  assign seg      = r_seg;
  assign an       = r_an;

endmodule

// File: tb/tb_bcd_scan_conv.sv
// Directed bench for bcd_scan_conv: a 4-digit and a 3-digit instance share stimulus.
module tb_bcd_scan_conv;

  logic        clk;
  logic        rst_n;
  logic [9:0]  bin_in;
  logic        start;
  logic        blank_lz;

  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic [6:0]  seg4;
  logic [3:0]  an4;

  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic [6:0]  seg3;
  logic [2:0]  an3;

  int n_pass  = 0;
  int n_total = 0;

  bcd_scan_conv #(.N_in(10), .N_DIG(4), .N_out(7), .SCAN_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .start(start), .blank_lz(blank_lz),
    .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4), .seg(seg4), .an(an4)
  );

  bcd_scan_conv #(.N_in(10), .N_DIG(3), .N_out(7), .SCAN_DIV(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .start(start), .blank_lz(blank_lz),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3), .seg(seg3), .an(an3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pulse_start(input logic [9:0] val);
    @(negedge clk);
    bin_in = val;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic scan_check(input logic blank);
    logic [3:0] prev;
    logic [3:0] one;
    logic [6:0] exp_seg;
    bit         found;
    one   = 4'b0001;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      prev = an4;
      @(negedge clk);
      if (prev == 4'b0111 && an4 == 4'b1110) found = 1'b1;
    end
    chk("scan_sync", {31'd0, found}, 32'd1);
    for (int d = 0; d < 4; d++) begin
      exp_seg = (d == 0) ? 7'b1111000 : (blank ? 7'b1111111 : 7'b1000000);
      for (int c = 0; c < 4; c++) begin
        chk("scan_an", {28'd0, an4}, {28'd0, ~(one << d)});
        chk("scan_seg", {25'd0, seg4}, {25'd0, exp_seg});
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int cnt;
    int last;
    rst_n    = 1'b0;
    start    = 1'b0;
    bin_in   = '0;
    blank_lz = 1'b1;

    // Reset state
    #22;
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_bcd", {16'd0, bcd4}, 32'h0);
    chk("rst_ovf", {31'd0, ovf4}, 32'd0);
    chk("rst_an", {28'd0, an4}, 32'hE);
    chk("rst_seg", {25'd0, seg4}, 32'h40);

    // 1023: start accepted on the first edge after reset release
    @(negedge clk);
    rst_n  = 1'b1;
    start  = 1'b1;
    bin_in = 10'd1023;
    @(negedge clk);
    start = 1'b0;
    chk("conv_busy_k", {31'd0, busy4}, 32'd1);
    chk("conv_done_k", {31'd0, done4}, 32'd0);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk("conv_busy_mid", {31'd0, busy4}, 32'd1);
      chk("conv_done_mid", {31'd0, done4}, 32'd0);
      chk("conv_bcd_hold", {16'd0, bcd4}, 32'h0);
    end
    @(negedge clk);
    chk("conv_done", {31'd0, done4}, 32'd1);
    chk("conv_busy_end", {31'd0, busy4}, 32'd0);
    chk("conv_bcd1023", {16'd0, bcd4}, 32'h1023);
    chk("conv_ovf1023", {31'd0, ovf4}, 32'd0);
    chk("d3_done", {31'd0, done3}, 32'd1);
    chk("d3_bcd1023", {20'd0, bcd3}, 32'h023);
    chk("d3_ovf1023", {31'd0, ovf3}, 32'd1);
    @(negedge clk);
    chk("conv_done_pulse", {31'd0, done4}, 32'd0);

    // 999 fits three digits
    pulse_start(10'd999);
    repeat (12) @(negedge clk);
    chk("d3_bcd999", {20'd0, bcd3}, 32'h999);
    chk("d3_ovf999", {31'd0, ovf3}, 32'd0);
    chk("d4_bcd999", {16'd0, bcd4}, 32'h0999);

    // start while busy is ignored
    pulse_start(10'd512);
    cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 2) begin
        start  = 1'b1;
        bin_in = 10'd5;
      end
      if (c == 3) start = 1'b0;
      if (done4) cnt++;
    end
    chk("busy_ign_cnt", cnt, 32'd1);
    chk("busy_ign_bcd", {16'd0, bcd4}, 32'h0512);
    chk("busy_ign_idle", {31'd0, busy4}, 32'd0);

    // start held high with zero input: back-to-back conversions every 12 cycles
    @(negedge clk);
    bin_in = 10'd0;
    start  = 1'b1;
    cnt    = 0;
    last   = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done4) begin
        if (last >= 0) chk("held_period", c - last, 32'd12);
        chk("held_bcd", {16'd0, bcd4}, 32'h0);
        last = c;
        cnt++;
      end
    end
    chk("held_cnt", cnt, 32'd5);
    start = 1'b0;
    repeat (14) @(negedge clk);

    // Display scan with 0007
    pulse_start(10'd7);
    repeat (14) @(negedge clk);
    chk("scan_bcd", {16'd0, bcd4}, 32'h0007);
    blank_lz = 1'b1;
    scan_check(1'b1);
    blank_lz = 1'b0;
    scan_check(1'b0);

    // Reset mid-conversion aborts it
    pulse_start(10'd1023);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy4}, 32'd0);
    chk("abort_done", {31'd0, done4}, 32'd0);
    chk("abort_bcd", {16'd0, bcd4}, 32'h0);
    chk("abort_ovf", {31'd0, ovf4}, 32'd0);
    chk("abort_an", {28'd0, an4}, 32'hE);
    chk("abort_seg", {25'd0, seg4}, 32'h40);
    chk("abort_d3_bcd", {20'd0, bcd3}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done4 || busy4) cnt++;
    end
    chk("abort_no_done", cnt, 32'd0);
    chk("abort_bcd_end", {16'd0, bcd4}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
